// File: rtl/costas_integrate_dump.sv
// Integrate-and-dump for the Costas loop arms: windowed I/Q sums with saturation,
// scaled outputs at each dump strobe, and a sign(I)*Q phase error one cycle later.
module costas_integrate_dump #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 10,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dump,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    output logic signed [OUT_W-1:0]  i_out,
    output logic signed [OUT_W-1:0]  q_out,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         win_count,
    output logic                     ovf,
    output logic signed [OUT_W-1:0]  err_out,
    output logic                     err_valid
);

    logic signed [DATA_W-1:0] w_sample [2];
    logic signed [OUT_W-1:0]  w_scaled [2];
    logic [1:0]               w_acc_sat;
    logic [1:0]               w_out_sat;

    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_final;
    logic                     r_wovf;

    logic signed [OUT_W-1:0]  r_i_out;
    logic signed [OUT_W-1:0]  r_q_out;
    logic                     r_out_valid;
    logic [CNT_W-1:0]         r_win_count;
    logic                     r_ovf;
    logic signed [OUT_W-1:0]  r_err_out;
    logic                     r_err_valid;
    logic signed [OUT_W-1:0]  w_err;
    logic                     w_q_is_min;

    assign w_sample[0] = i_in;
    assign w_sample[1] = q_in;

    // Channel 0 is I, channel 1 is Q; both share the dump/valid controls.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [ACC_W-1:0]     r_acc;
            logic signed [ACC_W:0]       w_add;
            logic signed [ACC_W:0]       w_sum_wide;
            logic signed [ACC_W-1:0]     w_sum;
            logic signed [ACC_W-1:0]     w_shifted;
            logic [ACC_W-OUT_W:0]        w_hi;

            assign w_add      = in_valid ? (ACC_W+1)'(w_sample[gi]) : '0;
            assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + w_add;

            // One guard bit: overflow iff the two top bits disagree.
            assign w_acc_sat[gi] = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
            assign w_sum = w_acc_sat[gi]
                         ? {w_sum_wide[ACC_W], {(ACC_W-1){~w_sum_wide[ACC_W]}}}
                         : w_sum_wide[ACC_W-1:0];

            assign w_shifted     = w_sum >>> SHIFT;
            assign w_hi          = w_shifted[ACC_W-1:OUT_W-1];
            assign w_out_sat[gi] = ~((&w_hi) | ~(|w_hi));
            assign w_scaled[gi]  = w_out_sat[gi]
                                 ? {w_shifted[ACC_W-1], {(OUT_W-1){~w_shifted[ACC_W-1]}}}
                                 : w_shifted[OUT_W-1:0];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_acc <= '0;
                end else if (dump) begin
                    r_acc <= '0;
                end else if (in_valid) begin
                    r_acc <= w_sum;
                end
            end
        end
    endgenerate

    assign w_cnt_final = (in_valid && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

    // Negating the most negative value would wrap, so clamp it to the maximum.
    assign w_q_is_min = r_q_out[OUT_W-1] & ~(|r_q_out[OUT_W-2:0]);
    assign w_err = !r_i_out[OUT_W-1] ? r_q_out
                 : (w_q_is_min ? {1'b0, {(OUT_W-1){1'b1}}} : -r_q_out);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_wovf      <= 1'b0;
            r_i_out     <= '0;
            r_q_out     <= '0;
            r_out_valid <= 1'b0;
            r_win_count <= '0;
            r_ovf       <= 1'b0;
            r_err_out   <= '0;
            r_err_valid <= 1'b0;
        end else begin
            r_out_valid <= dump;
            r_err_valid <= r_out_valid;
            if (r_out_valid) begin
                r_err_out <= w_err;
            end
            if (dump) begin
                r_i_out     <= w_scaled[0];
                r_q_out     <= w_scaled[1];
                r_win_count <= w_cnt_final;
                r_ovf       <= r_wovf | (|w_acc_sat) | (|w_out_sat);
                r_cnt       <= '0;
                r_wovf      <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_final;
                r_wovf <= r_wovf | (|w_acc_sat);
            end
        end
    end

    assign i_out     = r_i_out;
    assign q_out     = r_q_out;
    assign out_valid = r_out_valid;
    assign win_count = r_win_count;
    assign ovf       = r_ovf;
    assign err_out   = r_err_out;
    assign err_valid = r_err_valid;

endmodule

// File: tb/tb_costas_integrate_dump.sv
// Bench for costas_integrate_dump: a default instance and a SHIFT=0 instance share
// stimulus; a window model pushes expected dumps to a scoreboard popped on out_valid.
module tb_costas_integrate_dump;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dump = 1'b0;
    logic in_valid = 1'b0;
    logic signed [11:0] i_in = '0;
    logic signed [11:0] q_in = '0;

    logic signed [15:0] a_i, a_q, a_err, b_i, b_q, b_err;
    logic [9:0]         a_cnt, b_cnt;
    logic               a_ov, a_ovf, a_ev, b_ov, b_ovf, b_ev;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int i_a; int q_a; bit ovf_a;
        int i_b; int q_b; bit ovf_b;
        int cnt;
    } exp_t;
    typedef struct { int err_a; int err_b; } err_t;

    exp_t exp_q[$];
    err_t err_q[$];

    longint m_i = 0, m_q = 0;
    int     m_cnt = 0;
    bit     m_wovf = 0;
    bit     pa = 0, pb = 0;

    always #5 clock = ~clock;

    costas_integrate_dump dut_a (
        .clock(clock), .reset(reset), .dump(dump), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .i_out(a_i), .q_out(a_q), .out_valid(a_ov),
        .win_count(a_cnt), .ovf(a_ovf), .err_out(a_err), .err_valid(a_ev)
    );

    costas_integrate_dump #(.SHIFT(0)) dut_b (
        .clock(clock), .reset(reset), .dump(dump), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .i_out(b_i), .q_out(b_q), .out_valid(b_ov),
        .win_count(b_cnt), .ovf(b_ovf), .err_out(b_err), .err_valid(b_ev)
    );

    function automatic longint acc_clamp(input longint s, output bit sat);
        sat = 1'b0;
        if (s > 64'sd8388607) begin acc_clamp = 64'sd8388607; sat = 1'b1; end
        else if (s < -64'sd8388608) begin acc_clamp = -64'sd8388608; sat = 1'b1; end
        else acc_clamp = s;
    endfunction

    function automatic int scale(input longint s, input int sh, output bit sat);
        longint v;
        v = s >>> sh;
        sat = 1'b0;
        if (v > 32767) begin v = 32767; sat = 1'b1; end
        else if (v < -32768) begin v = -32768; sat = 1'b1; end
        scale = int'(v);
    endfunction

    function automatic int perr(input int i, input int q);
        if (i >= 0) return q;
        if (q == -32768) return 32767;
        return -q;
    endfunction

    // Drive one cycle; the model tracks what the DUT should accept on this edge.
    task automatic step(input bit v, input int iv, input int qv, input bit d);
        bit s1, s2, s3, s4;
        exp_t e;
        in_valid = v; dump = d;
        i_in = 12'(iv); q_in = 12'(qv);
        if (!reset) begin
            if (v) begin
                m_i = acc_clamp(m_i + iv, s1);
                m_q = acc_clamp(m_q + qv, s2);
                m_wovf = m_wovf | s1 | s2;
                if (m_cnt < 1023) m_cnt++;
            end
            if (d) begin
                e.cnt = m_cnt;
                e.i_a = scale(m_i, 10, s1); e.q_a = scale(m_q, 10, s2);
                e.ovf_a = m_wovf | s1 | s2;
                e.i_b = scale(m_i, 0, s3);  e.q_b = scale(m_q, 0, s4);
                e.ovf_b = m_wovf | s3 | s4;
                exp_q.push_back(e);
                m_i = 0; m_q = 0; m_cnt = 0; m_wovf = 0;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0; dump = 1'b0;
    endtask

    // Scoreboard: pop on out_valid / err_valid, sampled away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        err_t r;
        if (!reset) begin
            if (a_ov || b_ov) begin
                n_checks++; if (a_ov !== b_ov) $display("FAIL ov_align a=%0b b=%0b", a_ov, b_ov); else n_pass++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_out_valid got pulse want none");
                end else begin
                    n_pass++;
                    e = exp_q.pop_front();
                    $display("dump: cnt=%0d a(i=%0d q=%0d ovf=%0b) b(i=%0d q=%0d ovf=%0b)", a_cnt, a_i, a_q, a_ovf, b_i, b_q, b_ovf);
                    n_checks++; if (a_i !== e.i_a) $display("FAIL sb_i_a got %0d want %0d", a_i, e.i_a); else n_pass++;
                    n_checks++; if (a_q !== e.q_a) $display("FAIL sb_q_a got %0d want %0d", a_q, e.q_a); else n_pass++;
                    n_checks++; if (a_ovf !== e.ovf_a) $display("FAIL sb_ovf_a got %0b want %0b", a_ovf, e.ovf_a); else n_pass++;
                    n_checks++; if (a_cnt !== 10'(e.cnt)) $display("FAIL sb_cnt_a got %0d want %0d", a_cnt, e.cnt); else n_pass++;
                    n_checks++; if (b_i !== e.i_b) $display("FAIL sb_i_b got %0d want %0d", b_i, e.i_b); else n_pass++;
                    n_checks++; if (b_q !== e.q_b) $display("FAIL sb_q_b got %0d want %0d", b_q, e.q_b); else n_pass++;
                    n_checks++; if (b_ovf !== e.ovf_b) $display("FAIL sb_ovf_b got %0b want %0b", b_ovf, e.ovf_b); else n_pass++;
                    n_checks++; if (b_cnt !== 10'(e.cnt)) $display("FAIL sb_cnt_b got %0d want %0d", b_cnt, e.cnt); else n_pass++;
                    r.err_a = perr(e.i_a, e.q_a);
                    r.err_b = perr(e.i_b, e.q_b);
                    err_q.push_back(r);
                end
            end
            if (a_ev || pa) begin
                n_checks++; if (a_ev !== pa) $display("FAIL err_timing_a got %0b want %0b", a_ev, pa); else n_pass++;
            end
            if (b_ev || pb) begin
                n_checks++; if (b_ev !== pb) $display("FAIL err_timing_b got %0b want %0b", b_ev, pb); else n_pass++;
            end
            if ((a_ev || b_ev) && err_q.size() != 0) begin
                r = err_q.pop_front();
                $display("err: a=%0d b=%0d", a_err, b_err);
                n_checks++; if (a_err !== r.err_a) $display("FAIL sb_err_a got %0d want %0d", a_err, r.err_a); else n_pass++;
                n_checks++; if (b_err !== r.err_b) $display("FAIL sb_err_b got %0d want %0d", b_err, r.err_b); else n_pass++;
            end
        end
        pa = reset ? 1'b0 : a_ov;
        pb = reset ? 1'b0 : b_ov;
    end

    task automatic test_reset;
        reset = 1'b1; dump = 1'b1; in_valid = 1'b1; i_in = 12'sd100; q_in = 12'sd7;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (a_ov !== 1'b0 || b_ov !== 1'b0) $display("FAIL rst_out_valid got %0b/%0b want 0", a_ov, b_ov); else n_pass++;
        n_checks++; if (a_ev !== 1'b0 || b_ev !== 1'b0) $display("FAIL rst_err_valid got %0b/%0b want 0", a_ev, b_ev); else n_pass++;
        n_checks++; if (a_i !== 0 || a_q !== 0) $display("FAIL rst_iq got %0d/%0d want 0", a_i, a_q); else n_pass++;
        n_checks++; if (a_cnt !== 0 || a_ovf !== 1'b0) $display("FAIL rst_cnt_ovf got %0d/%0b want 0", a_cnt, a_ovf); else n_pass++;
        n_checks++; if (a_err !== 0 || b_err !== 0) $display("FAIL rst_err got %0d/%0d want 0", a_err, b_err); else n_pass++;
        dump = 1'b0; in_valid = 1'b0;
        reset = 1'b0;
        step(0, 0, 0, 0);
    endtask

    task automatic test_nominal;
        for (int k = 0; k < 599; k++) step(1, 100, -50, 0);
        step(1, 100, -50, 1);
        n_checks++; if (a_ov !== 1'b1) $display("FAIL nom_out_valid got %0b want 1", a_ov); else n_pass++;
        n_checks++; if (a_i !== 58) $display("FAIL nom_i got %0d want 58", a_i); else n_pass++;
        n_checks++; if (a_q !== -30) $display("FAIL nom_q got %0d want -30", a_q); else n_pass++;
        n_checks++; if (a_cnt !== 10'd600) $display("FAIL nom_cnt got %0d want 600", a_cnt); else n_pass++;
        n_checks++; if (a_ovf !== 1'b0) $display("FAIL nom_ovf got %0b want 0", a_ovf); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (a_ev !== 1'b1 || a_ov !== 1'b0) $display("FAIL nom_err_valid got %0b/%0b want 1/0", a_ev, a_ov); else n_pass++;
        n_checks++; if (a_err !== -30) $display("FAIL nom_err got %0d want -30", a_err); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (a_ev !== 1'b0 || a_err !== -30 || a_i !== 58) $display("FAIL nom_hold got ev=%0b err=%0d i=%0d want 0/-30/58", a_ev, a_err, a_i); else n_pass++;
    endtask

    task automatic test_empty;
        repeat (20) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        n_checks++; if (a_ov !== 1'b1) $display("FAIL empty_out_valid got %0b want 1", a_ov); else n_pass++;
        n_checks++; if (a_i !== 0 || a_q !== 0 || a_cnt !== 0 || a_ovf !== 1'b0) $display("FAIL empty_fields got i=%0d q=%0d cnt=%0d ovf=%0b want 0", a_i, a_q, a_cnt, a_ovf); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (a_ev !== 1'b1 || a_err !== 0) $display("FAIL empty_err got ev=%0b err=%0d want 1/0", a_ev, a_err); else n_pass++;
    endtask

    task automatic test_out_sat;
        for (int k = 0; k < 599; k++) step(1, 2047, 0, 0);
        step(1, 2047, 0, 1);
        n_checks++; if (b_i !== 32767 || b_q !== 0) $display("FAIL osat_iq got %0d/%0d want 32767/0", b_i, b_q); else n_pass++;
        n_checks++; if (b_ovf !== 1'b1) $display("FAIL osat_ovf got %0b want 1", b_ovf); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (b_err !== 0) $display("FAIL osat_err got %0d want 0", b_err); else n_pass++;
        for (int k = 0; k < 4; k++) step(1, 2047, 0, 0);
        step(1, 2047, 0, 1);
        n_checks++; if (b_ovf !== 1'b0 || b_i !== 10235) $display("FAIL osat_next got ovf=%0b i=%0d want 0/10235", b_ovf, b_i); else n_pass++;
        step(0, 0, 0, 0);
    endtask

    task automatic test_neg_sat;
        for (int k = 0; k < 15; k++) step(1, -1, -2048, 0);
        step(1, -1, -2048, 1);
        n_checks++; if (b_i !== -16 || b_q !== -32768) $display("FAIL nsat_iq got %0d/%0d want -16/-32768", b_i, b_q); else n_pass++;
        n_checks++; if (a_i !== -1 || a_q !== -32) $display("FAIL nsat_iq_a got %0d/%0d want -1/-32", a_i, a_q); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (b_err !== 32767) $display("FAIL nsat_err got %0d want 32767", b_err); else n_pass++;
        n_checks++; if (a_err !== 32) $display("FAIL nsat_err_a got %0d want 32", a_err); else n_pass++;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++) step(1, 3, 0, 0);
        step(1, 5, 0, 1);
        n_checks++; if (b_ov !== 1'b1 || b_i !== 17 || b_cnt !== 10'd5) $display("FAIL b2b_first got ov=%0b i=%0d cnt=%0d want 1/17/5", b_ov, b_i, b_cnt); else n_pass++;
        step(1, 5, 0, 1);
        n_checks++; if (b_ov !== 1'b1 || b_i !== 5 || b_cnt !== 10'd1) $display("FAIL b2b_second got ov=%0b i=%0d cnt=%0d want 1/5/1", b_ov, b_i, b_cnt); else n_pass++;
        n_checks++; if (a_i !== 0 || b_ev !== 1'b1) $display("FAIL b2b_second_a got i=%0d ev=%0b want 0/1", a_i, b_ev); else n_pass++;
        step(0, 0, 0, 1);
        n_checks++; if (b_ov !== 1'b1 || b_i !== 0 || b_cnt !== 10'd0 || b_ev !== 1'b1) $display("FAIL b2b_third got ov=%0b i=%0d cnt=%0d ev=%0b want 1/0/0/1", b_ov, b_i, b_cnt, b_ev); else n_pass++;
        step(0, 0, 0, 0);
        n_checks++; if (b_ov !== 1'b0 || b_ev !== 1'b1) $display("FAIL b2b_tail got ov=%0b ev=%0b want 0/1", b_ov, b_ev); else n_pass++;
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 300; k++) step(1, 1000, 0, 0);
        reset = 1'b1; dump = 1'b1; in_valid = 1'b1; i_in = 12'sd1000;
        m_i = 0; m_q = 0; m_cnt = 0; m_wovf = 0;
        @(posedge clock); #1;
        n_checks++; if (a_ov !== 1'b0 || a_ev !== 1'b0 || b_ov !== 1'b0 || b_ev !== 1'b0) $display("FAIL mid_rst_pulses got %0b%0b%0b%0b want 0000", a_ov, a_ev, b_ov, b_ev); else n_pass++;
        dump = 1'b0; in_valid = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) step(1, 1024, 0, 0);
        step(0, 0, 0, 1);
        n_checks++; if (a_cnt !== 10'd10 || a_i !== 10) $display("FAIL mid_rst_window got cnt=%0d i=%0d want 10/10", a_cnt, a_i); else n_pass++;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_nominal;
        test_empty;
        test_out_sat;
        test_neg_sat;
        test_back_to_back;
        test_reset_mid;
        n_checks++; if (exp_q.size() != 0 || err_q.size() != 0) $display("FAIL sb_drain got %0d/%0d want 0/0", exp_q.size(), err_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
